// File: rtl/mem_access_if.sv
// Bus bundle between the CPU load/store path and mem_access_unit.
// slave is the unit's view; master is the requester/memory side.
interface mem_access_if #(
    parameter int DATA_W = 32,
    parameter int OFS_W  = $clog2(DATA_W / 8)
);
    logic              start;
    logic [2:0]        op;
    logic              is_signed;
    logic [OFS_W-1:0]  addr_lo;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] load_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, op, is_signed, addr_lo, reg_data, mem_rdata,
        output mem_rd, mem_wr, mem_wdata, load_data, busy, done, err
    );

    modport master (
        output start, op, is_signed, addr_lo, reg_data, mem_rdata,
        input  mem_rd, mem_wr, mem_wdata, load_data, busy, done, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: lane select + extend for loads, read-modify-write for
// sub-word stores, with start/done handshake and misalignment/illegal-op flag.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    localparam int OFS_W = $clog2(DATA_W / 8);

    localparam logic [2:0] OP_LW = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd3;
    localparam logic [2:0] OP_SH = 3'd4;
    localparam logic [2:0] OP_SB = 3'd5;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              sgn_q, sgn_d;
    logic              err_q, err_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic [15:0]       src_q, src_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;

    logic [DATA_W-1:0] mask, lane, ext, merged, sw_word;
    logic [OFS_W+2:0]  sh;
    logic              msb, bad;

    function automatic logic [DATA_W-1:0] size_mask(input logic [2:0] op);
        case (op)
            OP_LW, OP_SW: size_mask = DATA_W'(32'hFFFF_FFFF);
            OP_LH, OP_SH: size_mask = DATA_W'(32'h0000_FFFF);
            default:      size_mask = DATA_W'(32'h0000_00FF);
        endcase
    endfunction

    always_comb begin
        case (bus.op)
            OP_LW, OP_SW: bad = (bus.addr_lo[1:0] != 2'b00);
            OP_LH, OP_SH: bad = bus.addr_lo[0];
            OP_LB, OP_SB: bad = 1'b0;
            default:      bad = 1'b1;
        endcase
    end

    // Lane datapath works on the latched request so later input changes are harmless.
    assign sh      = {ofs_q, 3'b000};
    assign mask    = size_mask(op_q);
    assign lane    = (bus.mem_rdata >> sh) & mask;
    assign ext     = (sgn_q && msb) ? (lane | ~mask) : lane;
    assign merged  = (bus.mem_rdata & ~(mask << sh)) | ((DATA_W'(src_q) & mask) << sh);
    assign sw_word = DATA_W'(bus.reg_data[31:0]) << {bus.addr_lo, 3'b000};

    always_comb begin
        case (op_q)
            OP_LB:   msb = lane[7];
            OP_LH:   msb = lane[15];
            default: msb = lane[31];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            ofs_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            ofs_q   <= ofs_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        ofs_d   = ofs_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    sgn_d = bus.is_signed;
                    ofs_d = bus.addr_lo;
                    src_d = bus.reg_data[15:0];
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (bus.op == OP_SW) begin
                        err_d   = 1'b0;
                        wdata_d = sw_word;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                cnt_d   = 2'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    // Loads finish here; SH/SB carry the merged word into WRITE.
                    if (op_q <= OP_LB) begin
                        ldata_d = ext;
                        state_d = DONE;
                    end else begin
                        wdata_d = merged;
                        state_d = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_rd    = (state_q == READ);
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) && err_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.load_data = ldata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle expectation schedule built
// from the latency/lane rules is checked against two DUTs (MEM_LAT 1 and 3).
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(32)) if1 ();
    mem_access_if #(.DATA_W(32)) if3 ();

    mem_access_unit #(.DATA_W(32), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    mem_access_unit #(.DATA_W(32), .MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

    int errors = 0;
    int checks = 0;

    // Memory: the word is visible only in the last latency cycle after mem_rd.
    logic [31:0] word1 = 32'h0, word3 = 32'h0;
    logic        p1;
    logic [2:0]  p3;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= 1'b0;
            p3 <= 3'b0;
        end else begin
            p1 <= if1.mem_rd;
            p3 <= {p3[1:0], if3.mem_rd};
        end
    end
    assign if1.mem_rdata = p1    ? word1 : 32'hDEADBEEF;
    assign if3.mem_rdata = p3[2] ? word3 : 32'hDEADBEEF;

    typedef struct {
        int          sel;
        logic        rd, wr, busy, done, err;
        logic [31:0] ld, wd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [31:0] cur_ld[2];
    logic [31:0] cur_wd[2];
    logic        a_rd, a_wr, a_busy, a_done, a_err;
    logic [31:0] a_ld, a_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            if (ce.sel == 0) begin
                a_rd = if1.mem_rd; a_wr = if1.mem_wr; a_busy = if1.busy;
                a_done = if1.done; a_err = if1.err; a_ld = if1.load_data; a_wd = if1.mem_wdata;
            end else begin
                a_rd = if3.mem_rd; a_wr = if3.mem_wr; a_busy = if3.busy;
                a_done = if3.done; a_err = if3.err; a_ld = if3.load_data; a_wd = if3.mem_wdata;
            end
            chk($sformatf("dut%0d.mem_rd", ce.sel), {31'b0, a_rd}, {31'b0, ce.rd});
            chk($sformatf("dut%0d.mem_wr", ce.sel), {31'b0, a_wr}, {31'b0, ce.wr});
            chk($sformatf("dut%0d.busy", ce.sel), {31'b0, a_busy}, {31'b0, ce.busy});
            chk($sformatf("dut%0d.done", ce.sel), {31'b0, a_done}, {31'b0, ce.done});
            chk($sformatf("dut%0d.err", ce.sel), {31'b0, a_err}, {31'b0, ce.err});
            chk($sformatf("dut%0d.load_data", ce.sel), a_ld, ce.ld);
            chk($sformatf("dut%0d.mem_wdata", ce.sel), a_wd, ce.wd);
        end
    end

    task automatic drive(input int sel, input logic st, input logic [2:0] op, input logic sg,
                         input logic [1:0] ofs, input logic [31:0] rdat);
        if (sel == 0) begin
            if1.start = st; if1.op = op; if1.is_signed = sg; if1.addr_lo = ofs; if1.reg_data = rdat;
        end else begin
            if3.start = st; if3.op = op; if3.is_signed = sg; if3.addr_lo = ofs; if3.reg_data = rdat;
        end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 0) if1.start = st;
        else          if3.start = st;
    endtask

    task automatic push(input int sel, input logic rd, wr, busy, done, err, input logic [31:0] ld, wd);
        exp_t e;
        e.sel = sel; e.rd = rd; e.wr = wr; e.busy = busy; e.done = done; e.err = err;
        e.ld = ld; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int sel, input int k);
        for (int i = 0; i < k; i++) begin
            push(sel, 0, 0, 0, 0, 0, cur_ld[sel], cur_wd[sel]);
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1 of the cycle in which start is raised (cycle 0).
    task automatic txn(input int sel, input logic [2:0] op, input logic sgn, input logic [1:0] ofs,
                       input logic [31:0] regd, input logic [31:0] word, input bit poke);
        int          lat, sz, n;
        bit          legal, load, store;
        logic [31:0] mask, lane, new_ld, new_wd;
        lat   = (sel == 0) ? 1 : 3;
        sz    = (op == 3'd0 || op == 3'd3) ? 4 : (op == 3'd1 || op == 3'd4) ? 2 : 1;
        legal = (op <= 3'd5) && ((int'(ofs) % sz) == 0);
        load  = legal && (op <= 3'd2);
        store = legal && (op >= 3'd3);
        mask  = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        new_ld = cur_ld[sel];
        new_wd = cur_wd[sel];
        if (!legal) n = 1;
        else if (op == 3'd3) n = 2;
        else if (load) n = lat + 2;
        else n = lat + 3;
        if (load) begin
            lane = (word >> (8 * ofs)) & mask;
            new_ld = (sgn && ((lane & ((mask >> 1) + 1)) != 0)) ? (lane | ~mask) : lane;
        end
        if (op == 3'd3 && legal) new_wd = regd << (8 * ofs);
        else if (store) new_wd = (word & ~(mask << (8 * ofs))) | ((regd & mask) << (8 * ofs));

        if (sel == 0) word1 = word; else word3 = word;
        drive(sel, 1'b1, op, sgn, ofs, regd);
        push(sel, 0, 0, 0, 0, 0, cur_ld[sel], cur_wd[sel]);
        for (int c = 1; c <= n; c++)
            push(sel, legal && op != 3'd3 && c == 1, store && c == n - 1, 1'b1, c == n,
                 c == n && !legal, (load && c == n) ? new_ld : cur_ld[sel],
                 (store && c >= n - 1) ? new_wd : cur_wd[sel]);
        cur_ld[sel] = new_ld;
        cur_wd[sel] = new_wd;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(sel, 1'b0, ~op, ~sgn, ~ofs, ~regd);
            if (poke) set_start(sel, (c == 2) || (c == n));
        end
        @(posedge clk); #1;
        set_start(sel, 1'b0);
    endtask

    task automatic pin(input int sel, input bit is_ld, input logic [31:0] lit);
        if (is_ld) begin
            chk("model.load_data", cur_ld[sel], lit);
            chk($sformatf("dut%0d.load_data_pin", sel), (sel == 0) ? if1.load_data : if3.load_data, lit);
        end else begin
            chk("model.mem_wdata", cur_wd[sel], lit);
            chk($sformatf("dut%0d.mem_wdata_pin", sel), (sel == 0) ? if1.mem_wdata : if3.mem_wdata, lit);
        end
    endtask

    task automatic chk_zero(input int sel, input string tag);
        if (sel == 0)
            chk({tag, ".dut0_outs"}, {if1.mem_rd, if1.mem_wr, if1.busy, if1.done, if1.err} == 5'b0 &&
                if1.load_data == 32'h0 && if1.mem_wdata == 32'h0 ? 32'h0 : 32'h1, 32'h0);
        else
            chk({tag, ".dut1_outs"}, {if3.mem_rd, if3.mem_wr, if3.busy, if3.done, if3.err} == 5'b0 &&
                if3.load_data == 32'h0 && if3.mem_wdata == 32'h0 ? 32'h0 : 32'h1, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cur_ld[0] = 0; cur_ld[1] = 0; cur_wd[0] = 0; cur_wd[1] = 0;
        drive(0, 0, 3'd0, 0, 2'd0, 32'h0);
        drive(1, 0, 3'd0, 0, 2'd0, 32'h0);
        #1;
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(0, 1);

        // Loads on MEM_LAT=1
        txn(0, 3'd2, 1, 2'd1, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'hFFFFFFF2);
        txn(0, 3'd2, 0, 2'd1, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'h000000F2);
        txn(0, 3'd1, 1, 2'd2, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'hFFFF8001);
        txn(0, 3'd1, 1, 2'd0, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'hFFFFF27F);
        txn(0, 3'd1, 0, 2'd2, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'h00008001);
        txn(0, 3'd0, 1, 2'd0, 32'h0, 32'h8001F27F, 0); pin(0, 1, 32'h8001F27F);
        // Stores
        txn(0, 3'd5, 0, 2'd3, 32'h123456AB, 32'h8001F27F, 0); pin(0, 0, 32'hAB01F27F);
        txn(0, 3'd4, 0, 2'd0, 32'hCAFE55AA, 32'h8001F27F, 0); pin(0, 0, 32'h800155AA);
        txn(0, 3'd3, 0, 2'd0, 32'h11223344, 32'h8001F27F, 0); pin(0, 0, 32'h11223344);
        // Errors: misaligned half/word, illegal opcodes; results unchanged
        txn(0, 3'd1, 1, 2'd1, 32'h0, 32'h8001F27F, 0);
        txn(0, 3'd7, 0, 2'd0, 32'h0, 32'h8001F27F, 0);
        txn(0, 3'd3, 0, 2'd2, 32'h55667788, 32'h8001F27F, 0);
        txn(0, 3'd6, 0, 2'd0, 32'h0, 32'h8001F27F, 0);
        pin(0, 1, 32'h8001F27F);
        pin(0, 0, 32'h11223344);
        idle(0, 2);

        // MEM_LAT=3: stray starts while busy and during DONE are ignored
        idle(1, 1);
        txn(1, 3'd0, 0, 2'd0, 32'h0, 32'h89ABCDEF, 1); pin(1, 1, 32'h89ABCDEF);
        idle(1, 2);
        txn(1, 3'd5, 0, 2'd1, 32'h0000005A, 32'h01020304, 0); pin(1, 0, 32'h01025A04);
        txn(1, 3'd1, 1, 2'd2, 32'h0, 32'h7FFF1234, 0); pin(1, 1, 32'h00007FFF);

        // Reset in the middle of an SH wait phase
        word3 = 32'hA5A5A5A5;
        drive(1, 1'b1, 3'd4, 0, 2'd2, 32'h00001234);
        @(posedge clk); #1; drive(1, 1'b0, 3'd4, 0, 2'd2, 32'h00001234);
        @(posedge clk); #1;
        chk("pre_reset.dut1_busy", {31'b0, if3.busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk_zero(1, "midop_reset");
        chk_zero(0, "midop_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_reset.dut1_mem_wr", {31'b0, if3.mem_wr}, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cur_ld[0] = 0; cur_ld[1] = 0; cur_wd[0] = 0; cur_wd[1] = 0;
        idle(1, 3);
        txn(1, 3'd2, 1, 2'd1, 32'h0, 32'h8001F27F, 0); pin(1, 1, 32'hFFFFFFF2);
        pin(1, 0, 32'h00000000);
        idle(1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
